// File: rtl/instr_queue_decoder.sv
// instr_queue_decoder: DEPTH-entry instruction queue that decodes R/I/J/S fields at enqueue; optional IQD_ILLEGAL_DETECT_EN adds illegal_op
module instr_queue_decoder #(
  parameter int INSTR_W = 32,
  parameter int OP_W    = 6,
  parameter int REG_W   = 4,
  parameter int IMM_W   = 16,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instr_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [1:0]                 fmt,
  output logic [OP_W-1:0]            opcode,
  output logic [REG_W-1:0]           rd,
  output logic [REG_W-1:0]           rs1,
  output logic [REG_W-1:0]           rs2,
  output logic [IMM_W-1:0]           immediate,
  output logic [INSTR_W-OP_W-1:0]    jump_offset,
  output logic [$clog2(DEPTH):0]     count
`ifdef IQD_ILLEGAL_DETECT_EN
  ,
  output logic                       illegal_op
`endif
);
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int JW      = INSTR_W - OP_W;
  localparam int RD_LSB  = INSTR_W - OP_W - REG_W;
  localparam int RS1_LSB = RD_LSB - REG_W;
  localparam int RS2_LSB = RS1_LSB - REG_W;
  localparam int IMM_LSB = RS1_LSB - IMM_W;
  // Opcode map boundaries: R 0..2, I 3..11, J 12..14, S 15..16
  localparam logic [31:0] R_MAX = 32'd2;
  localparam logic [31:0] I_MAX = 32'd11;
  localparam logic [31:0] J_MAX = 32'd14;
  localparam logic [31:0] S_MAX = 32'd16;

  typedef struct packed {
    logic [INSTR_W-1:0] raw;
    logic [1:0]         fmt;
    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [IMM_W-1:0]   imm;
    logic [JW-1:0]      joff;
`ifdef IQD_ILLEGAL_DETECT_EN
    logic               ill;
`endif
  } ent_t;

  ent_t            mem [DEPTH];
  ent_t            dec;
  ent_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [31:0]     opi;
  logic            push;
  logic            pop;

  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Decode the incoming word so the head path is pure storage readout
  always_comb begin
    dec     = '0;
    dec.raw = instr_in;
    dec.op  = instr_in[INSTR_W-1 -: OP_W];
    opi     = 32'(dec.op);
    if (opi <= R_MAX) begin
      dec.fmt = 2'b00;
      dec.rd  = instr_in[RD_LSB +: REG_W];
      dec.rs1 = instr_in[RS1_LSB +: REG_W];
      dec.rs2 = instr_in[RS2_LSB +: REG_W];
    end else if (opi <= I_MAX) begin
      dec.fmt = 2'b01;
      dec.rd  = instr_in[RD_LSB +: REG_W];
      dec.rs1 = instr_in[RS1_LSB +: REG_W];
      dec.imm = instr_in[IMM_LSB +: IMM_W];
    end else if (opi <= J_MAX) begin
      dec.fmt  = 2'b10;
      dec.joff = instr_in[JW-1:0];
    end else if (opi <= S_MAX) begin
      dec.fmt = 2'b11;
      dec.rd  = instr_in[RD_LSB +: REG_W];
    end else begin
`ifdef IQD_ILLEGAL_DETECT_EN
      dec.ill = 1'b1;
`endif
    end
  end

  // Queue storage, pointers and occupancy; flush empties without clearing storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign instr_out   = head.raw;
  assign fmt         = head.fmt;
  assign opcode      = head.op;
  assign rd          = head.rd;
  assign rs1         = head.rs1;
  assign rs2         = head.rs2;
  assign immediate   = head.imm;
  assign jump_offset = head.joff;
`ifdef IQD_ILLEGAL_DETECT_EN
  assign illegal_op  = head.ill;
`endif
endmodule

// File: tb/tb_instr_queue_decoder.sv
// tb_instr_queue_decoder: scoreboard bench for instr_queue_decoder (default parameters)
module tb_instr_queue_decoder;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] instr_in = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] instr_out;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [3:0]  rd, rs1, rs2;
  logic [15:0] immediate;
  logic [25:0] jump_offset;
  logic [2:0]  count;
`ifdef IQD_ILLEGAL_DETECT_EN
  logic        illegal_op;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] raw;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic [25:0] joff;
    logic        ill;
  } exp_t;

  exp_t q[$];

  localparam logic [31:0] W_ADD  = {6'd1, 4'd2, 4'd3, 4'd4, 14'd0};
  localparam logic [31:0] W_ADDI = {6'd4, 4'd5, 4'd6, 16'd10, 2'b01};
  localparam logic [31:0] W_JMP  = {6'd12, 26'd15};
  localparam logic [31:0] W_PUSH = {6'd15, 4'd7, 22'd0};
  localparam logic [31:0] W_BAD  = {6'h3F, 26'h2AB_CDEF};

  instr_queue_decoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .immediate(immediate), .jump_offset(jump_offset), .count(count)
`ifdef IQD_ILLEGAL_DETECT_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e = '0;
    int   op = int'(w[31:26]);
    e.raw = w;
    e.op  = w[31:26];
    if (op <= 2) begin
      e.fmt = 2'b00; e.rd = w[25:22]; e.rs1 = w[21:18]; e.rs2 = w[17:14];
    end else if (op <= 11) begin
      e.fmt = 2'b01; e.rd = w[25:22]; e.rs1 = w[21:18]; e.imm = w[17:2];
    end else if (op <= 14) begin
      e.fmt = 2'b10; e.joff = w[25:0];
    end else if (op <= 16) begin
      e.fmt = 2'b11; e.rd = w[25:22];
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    exp_t e = (q.size() != 0) ? q[0] : '0;
    check("count", 64'(count), 64'(q.size()));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 4));
    check("instr_out", 64'(instr_out), 64'(e.raw));
    check("fmt", 64'(fmt), 64'(e.fmt));
    check("opcode", 64'(opcode), 64'(e.op));
    check("rd", 64'(rd), 64'(e.rd));
    check("rs1", 64'(rs1), 64'(e.rs1));
    check("rs2", 64'(rs2), 64'(e.rs2));
    check("immediate", 64'(immediate), 64'(e.imm));
    check("jump_offset", 64'(jump_offset), 64'(e.joff));
`ifdef IQD_ILLEGAL_DETECT_EN
    check("illegal_op", 64'(illegal_op), 64'(e.ill));
`endif
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f);
    bit do_pop, do_push;
    in_valid = v; instr_in = w; out_ready = r; flush = f;
    if (f) q.delete();
    else begin
      do_pop  = r && q.size() != 0;
      do_push = v && q.size() < 4;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ref_dec(w));
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0; flush = 0;
    check_state();
  endtask

  initial begin
    #12;
    check_state();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    step(1, W_ADD, 0, 0);
    check("t1_fmt", 64'(fmt), 64'd0);
    check("t1_rd", 64'(rd), 64'd2);
    check("t1_rs1", 64'(rs1), 64'd3);
    check("t1_rs2", 64'(rs2), 64'd4);
    step(1, W_ADDI, 1, 0);
    check("t2_fmt", 64'(fmt), 64'd1);
    check("t2_imm", 64'(immediate), 64'd10);
    check("t2_rd", 64'(rd), 64'd5);
    check("t2_rs2", 64'(rs2), 64'd0);
    step(1, W_JMP, 1, 0);
    check("t3_fmt", 64'(fmt), 64'd2);
    check("t3_joff", 64'(jump_offset), 64'd15);
    step(1, W_PUSH, 1, 0);
    check("t3_push_fmt", 64'(fmt), 64'd3);
    check("t3_push_rd", 64'(rd), 64'd7);
    check("t3_push_rs1", 64'(rs1), 64'd0);
    step(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, {6'(i), 4'(i + 1), 22'(i * 3 + 1)}, 0, 0);
    check("t4_full_count", 64'(count), 64'd4);
    check("t4_full_ready", 64'(in_ready), 64'd0);
    step(1, W_ADDI, 1, 0);
    step(1, W_JMP, 0, 0);
    check("t4_ignored", 64'(count), 64'd4);
    step(0, '0, 1, 0);
    step(1, W_PUSH, 1, 0);
    check("t4_pushpop", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, {6'(i + 5), 26'(i * 77)}, 0, 0);
    step(1, W_ADD, 1, 1);
    check("t5_flush_count", 64'(count), 64'd0);
    check("t5_flush_valid", 64'(out_valid), 64'd0);
    step(1, W_BAD, 0, 0);
    check("t6_fmt", 64'(fmt), 64'd0);
    check("t6_rd", 64'(rd), 64'd0);
    check("t6_opcode", 64'(opcode), 64'h3F);
`ifdef IQD_ILLEGAL_DETECT_EN
    check("t6_illegal", 64'(illegal_op), 64'd1);
`endif
    step(0, '0, 1, 0);
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)),
           {($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom_range(0, 20)), 26'($urandom)},
           1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    step(1, W_ADD, 0, 0);
    step(1, W_JMP, 0, 0);
    #3 rst_n = 0;
    #1;
    check("async_count", 64'(count), 64'd0);
    check("async_valid", 64'(out_valid), 64'd0);
    q.delete();
    @(negedge clk); rst_n = 1;
    step(0, '0, 0, 0);
    step(1, W_ADDI, 0, 0);
    step(0, '0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
